// File: rtl/cell_window_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 window,
// one packed cell per interior pixel, raster order in, raster order out.
//
// state  | meaning
// FILL   | rows 0..1 of the frame arriving, no cells emitted
// STREAM | row >= 2, a cell is emitted for every accepted pixel with x >= 2
module cell_window_gen #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_in_valid,
  output logic                          pix_in_ready,
  input  logic [PIXEL_WIDTH-1:0]        pix_in_data,
  input  logic                          pix_in_sof,
  output logic                          cell_valid,
  input  logic                          cell_ready,
  output logic [9*PIXEL_WIDTH-1:0]      cell_data,
  output logic [$clog2(IMG_WIDTH)-1:0]  cell_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] cell_y,
  output logic                          cell_last
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] xLast = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] yLast = YW'(IMG_HEIGHT - 1);

  typedef enum logic {FILL, STREAM} stateT;

  stateT                  state;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [XW-1:0]          curX;
  logic [YW-1:0]          curY;
  logic                   accept;
  logic                   lineEnd;
  logic                   frameEnd;
  logic                   emit;
  logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb2 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1Old;
  logic [PIXEL_WIDTH-1:0] lb2Old;
  logic [PIXEL_WIDTH-1:0] win     [3][3];
  logic [PIXEL_WIDTH-1:0] winNext [3][3];
  logic [9*PIXEL_WIDTH-1:0] cellNext;

  assign pix_in_ready = !cell_valid || cell_ready;
  assign accept       = pix_in_valid && pix_in_ready;

  // A start-of-frame pixel is placed at (0,0) regardless of the counters.
  always_comb begin
    curX     = pix_in_sof ? '0 : x;
    curY     = pix_in_sof ? '0 : y;
    lineEnd  = (curX == xLast);
    frameEnd = lineEnd && (curY == yLast);
    emit     = (state == STREAM) && (curX >= XW'(2));
    lb1Old   = lb1[curX];
    lb2Old   = lb2[curX];
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      winNext[r][0] = win[r][1];
      winNext[r][1] = win[r][2];
      winNext[r][2] = '0;
    end
    winNext[0][2] = lb2Old;
    winNext[1][2] = lb1Old;
    winNext[2][2] = pix_in_data;
    cellNext = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        cellNext[PIXEL_WIDTH*(3*r+c) +: PIXEL_WIDTH] = winNext[r][c];
      end
    end
  end

  // Line buffers are plain RAM and keep their contents across reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[curX] <= lb1Old;
      lb1[curX] <= pix_in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FILL;
      x          <= '0;
      y          <= '0;
      cell_valid <= 1'b0;
      cell_data  <= '0;
      cell_x     <= '0;
      cell_y     <= '0;
      cell_last  <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      if (accept) begin
        win <= winNext;
        if (lineEnd) begin
          x <= '0;
          y <= frameEnd ? '0 : curY + YW'(1);
        end else begin
          x <= curX + XW'(1);
          y <= curY;
        end
        case (state)
          FILL:
            if (lineEnd && curY == YW'(1)) state <= STREAM;
          STREAM:
            if (frameEnd || pix_in_sof) state <= FILL;
          default:
            state <= FILL;
        endcase
      end

      if (accept && emit) begin
        cell_valid <= 1'b1;
        cell_data  <= cellNext;
        cell_x     <= curX - XW'(1);
        cell_y     <= curY - YW'(1);
        cell_last  <= frameEnd;
      end else if (cell_ready) begin
        cell_valid <= 1'b0;
      end
    end
  end

endmodule
